// File: rtl/bus_arbiter_rr_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr_if
// Groups the shared-bus arbitration signals between the bus masters and the
// round-robin arbiter.
//
// Parameter:
//   NR_OF_MASTERS      number of requesters (2..16)
//
// Signals:
//   requestIn          per-master level request, one bit per master
//   grantOut           registered one-hot grant, zero when nobody owns the bus
//   activeMasterOut    index of the current owner, 0 when idle
//   busIdleOut         1 while no grant is held
//   beginTransactionIn bus beginTransaction (OR of all masters)
//   dataValidIn        bus dataValid
//   busyIn             slave busy
//   endTransactionIn   endTransaction driven by the owner
//   endTransactionOut  arbiter-forced endTransaction, one-cycle pulse
//   busErrorOut        arbiter-forced busError, one-cycle pulse
//
// Modports:
//   slave  - arbiter side (consumes requests and bus activity, drives grants)
//   master - requester/bus side (drives requests and activity, sees grants)
// ---------------------------------------------------------------------------
interface bus_arbiter_rr_if #(
  parameter int NR_OF_MASTERS = 4
);
  logic [NR_OF_MASTERS-1:0] requestIn;
  logic [NR_OF_MASTERS-1:0] grantOut;
  logic [3:0]               activeMasterOut;
  logic                     busIdleOut;
  logic                     beginTransactionIn;
  logic                     dataValidIn;
  logic                     busyIn;
  logic                     endTransactionIn;
  logic                     endTransactionOut;
  logic                     busErrorOut;

  modport slave (
    input  requestIn, beginTransactionIn, dataValidIn, busyIn, endTransactionIn,
    output grantOut, activeMasterOut, busIdleOut, endTransactionOut, busErrorOut
  );

  modport master (
    output requestIn, beginTransactionIn, dataValidIn, busyIn, endTransactionIn,
    input  grantOut, activeMasterOut, busIdleOut, endTransactionOut, busErrorOut
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
// Round-robin arbiter for the shared system bus. Grants one master at a time,
// holds the grant until the owner ends its transaction, and uses a watchdog
// to abort an owner that stops showing bus activity (forced busError and/or
// endTransaction pulses), so a hung master cannot lock the bus.
//
// Parameters:
//   NR_OF_MASTERS   number of requesters, 2..16
//   TIMEOUT_CYCLES  max consecutive silent cycles while a grant is held, 2..65535
//
// Ports:
//   clock   system clock
//   reset   synchronous, active-high reset
//   bus     bus_arbiter_rr_if.slave (requests, bus activity, grant outputs)
//
// Build option:
//   BUS_ARB_FIXED_PRIORITY_EN  when defined, the priority pointer stays at 0,
//                              giving fixed priority with the lowest index
//                              winning; otherwise round-robin.
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int NR_OF_MASTERS  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             clock,
  input logic             reset,
  bus_arbiter_rr_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    GRANTED,
    ACTIVE,
    ABORT_ERR,
    ABORT_END
  } state_t;

  localparam int              WD_W     = 16;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  state_t                   r_state, w_nextState;
  logic [NR_OF_MASTERS-1:0] r_grant, w_nextGrant;
  logic [3:0]               r_activeMaster, w_nextActiveMaster;
  logic                     r_busIdle, w_nextBusIdle;
  logic                     r_endOut, w_nextEndOut;
  logic                     r_errOut, w_nextErrOut;
  logic [3:0]               r_pointer, w_nextPointer;
  logic [WD_W-1:0]          r_watchdog, w_nextWatchdog;

  logic       w_activity;
  logic       w_expire;
  logic       w_found;
  logic [3:0] w_winner;

  assign w_activity = bus.beginTransactionIn | bus.dataValidIn | bus.busyIn;
  // Activity in the current cycle clears the watchdog, so it cannot expire then.
  assign w_expire   = (r_watchdog == WD_LIMIT) && !w_activity;

  // Wrap-around scan: the first loop finds the lowest set request overall
  // (the wrapped candidate); the second overrides it with the lowest set
  // request at or above the pointer, if one exists.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NR_OF_MASTERS - 1; i >= 0; i--) begin
      if (bus.requestIn[i]) begin
        w_found  = 1'b1;
        w_winner = 4'(i);
      end
    end
    for (int i = NR_OF_MASTERS - 1; i >= 0; i--) begin
      if (bus.requestIn[i] && (i >= int'(r_pointer))) begin
        w_winner = 4'(i);
      end
    end
  end

  always_comb begin
    w_nextState        = r_state;
    w_nextGrant        = r_grant;
    w_nextActiveMaster = r_activeMaster;
    w_nextBusIdle      = r_busIdle;
    w_nextEndOut       = 1'b0;
    w_nextErrOut       = 1'b0;
    w_nextPointer      = r_pointer;

    // Watchdog holds while idle, otherwise clears on activity and saturates.
    if (r_state == IDLE) begin
      w_nextWatchdog = r_watchdog;
    end else if (w_activity) begin
      w_nextWatchdog = '0;
    end else if (r_watchdog < WD_LIMIT) begin
      w_nextWatchdog = r_watchdog + 1'b1;
    end else begin
      w_nextWatchdog = r_watchdog;
    end

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextState        = GRANTED;
          w_nextGrant        = {{(NR_OF_MASTERS-1){1'b0}}, 1'b1} << w_winner;
          w_nextActiveMaster = w_winner;
          w_nextBusIdle      = 1'b0;
          w_nextWatchdog     = '0;
`ifdef BUS_ARB_FIXED_PRIORITY_EN
          w_nextPointer      = '0;
`else
          w_nextPointer      = (w_winner == 4'(NR_OF_MASTERS - 1)) ? 4'd0 : w_winner + 4'd1;
`endif
        end
      end

      GRANTED: begin
        if (bus.beginTransactionIn) begin
          w_nextState = ACTIVE;
        end else if (w_expire) begin
          // The owner never started, so the abort ends without an error.
          w_nextState  = ABORT_END;
          w_nextEndOut = 1'b1;
        end
      end

      ACTIVE: begin
        // A real end beats a coinciding watchdog expiry.
        if (bus.endTransactionIn) begin
          w_nextState        = IDLE;
          w_nextGrant        = '0;
          w_nextActiveMaster = '0;
          w_nextBusIdle      = 1'b1;
        end else if (w_expire) begin
          w_nextState  = ABORT_ERR;
          w_nextErrOut = 1'b1;
        end
      end

      ABORT_ERR: begin
        w_nextState  = ABORT_END;
        w_nextEndOut = 1'b1;
      end

      ABORT_END: begin
        w_nextState        = IDLE;
        w_nextGrant        = '0;
        w_nextActiveMaster = '0;
        w_nextBusIdle      = 1'b1;
      end

      default: begin
        w_nextState        = IDLE;
        w_nextGrant        = '0;
        w_nextActiveMaster = '0;
        w_nextBusIdle      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_grant        <= '0;
      r_activeMaster <= '0;
      r_busIdle      <= 1'b1;
      r_endOut       <= 1'b0;
      r_errOut       <= 1'b0;
      r_pointer      <= '0;
      r_watchdog     <= '0;
    end else begin
      r_state        <= w_nextState;
      r_grant        <= w_nextGrant;
      r_activeMaster <= w_nextActiveMaster;
      r_busIdle      <= w_nextBusIdle;
      r_endOut       <= w_nextEndOut;
      r_errOut       <= w_nextErrOut;
      r_pointer      <= w_nextPointer;
      r_watchdog     <= w_nextWatchdog;
    end
  end

  assign bus.grantOut          = r_grant;
  assign bus.activeMasterOut   = r_activeMaster;
  assign bus.busIdleOut        = r_busIdle;
  assign bus.endTransactionOut = r_endOut;
  assign bus.busErrorOut       = r_errOut;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_rr
// Self-checking bench for bus_arbiter_rr with 4 masters and a 16-cycle
// watchdog. Directed scenarios check against hand-derived constants; a
// randomized run checks every cycle against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_rr;
  localparam int N = 4;
  localparam int T = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: who owns the bus, whether it started, how long it has
  // been silent, and which forced pulse (if any) is pending.
  int mOwner   = -1;
  int mPointer = 0;
  int mSilent  = 0;
  int mAbort   = 0;
  bit mStarted = 1'b0;
  bit mErr     = 1'b0;
  bit mEnd     = 1'b0;

  bus_arbiter_rr_if #(.NR_OF_MASTERS(N)) bus ();

  bus_arbiter_rr #(
    .NR_OF_MASTERS (N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic modelStep();
    bit activity;
    activity = bus.beginTransactionIn | bus.dataValidIn | bus.busyIn;
    mErr = 1'b0;
    mEnd = 1'b0;
    if (reset) begin
      mOwner = -1; mPointer = 0; mSilent = 0; mAbort = 0; mStarted = 1'b0;
    end else if (mOwner < 0) begin
      if (bus.requestIn != '0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mPointer + k) % N;
          if (mOwner < 0 && bus.requestIn[idx]) mOwner = idx;
        end
`ifdef BUS_ARB_FIXED_PRIORITY_EN
        mPointer = 0;
`else
        mPointer = (mOwner + 1) % N;
`endif
        mStarted = 1'b0;
        mSilent  = 0;
      end
    end else if (mAbort == 1) begin
      mAbort = 2;
      mEnd   = 1'b1;
    end else if (mAbort == 2) begin
      mAbort = 0;
      mOwner = -1;
    end else if (!mStarted) begin
      if (bus.beginTransactionIn) begin mStarted = 1'b1; mSilent = 0; end
      else if (activity) mSilent = 0;
      else if (mSilent == T - 1) begin mAbort = 2; mEnd = 1'b1; end
      else mSilent++;
    end else begin
      if (bus.endTransactionIn) mOwner = -1;
      else if (activity) mSilent = 0;
      else if (mSilent == T - 1) begin mAbort = 1; mErr = 1'b1; end
      else mSilent++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic clearInputs();
    bus.requestIn          = '0;
    bus.beginTransactionIn = 1'b0;
    bus.dataValidIn        = 1'b0;
    bus.busyIn             = 1'b0;
    bus.endTransactionIn   = 1'b0;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    compared++;
    if (bus.grantOut !== 4'b0000) begin
      mismatched++; $display("[TB] FAIL reset_grant actual=%b required=0000", bus.grantOut);
    end
    compared++;
    if (bus.activeMasterOut !== 4'd0) begin
      mismatched++; $display("[TB] FAIL reset_active actual=%0d required=0", bus.activeMasterOut);
    end
    compared++;
    if (bus.busIdleOut !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_idle actual=%b required=1", bus.busIdleOut);
    end
    compared++;
    if ({bus.endTransactionOut, bus.busErrorOut} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL reset_pulses actual=%b required=00",
                             {bus.endTransactionOut, bus.busErrorOut});
    end
  endtask

  task automatic test_single_request();
    bus.requestIn = 4'b0010;
    tick();
    compared++;
    if (bus.grantOut !== 4'b0010 || bus.activeMasterOut !== 4'd1 || bus.busIdleOut !== 1'b0) begin
      mismatched++; $display("[TB] FAIL single_grant actual=%b/%0d/%b required=0010/1/0",
                             bus.grantOut, bus.activeMasterOut, bus.busIdleOut);
    end
    bus.requestIn = '0;
    tick();
    tick();
    bus.beginTransactionIn = 1'b1;
    tick();
    bus.beginTransactionIn = 1'b0;
    repeat (6) tick();
    compared++;
    if (bus.grantOut !== 4'b0010) begin
      mismatched++; $display("[TB] FAIL single_hold actual=%b required=0010", bus.grantOut);
    end
    bus.endTransactionIn = 1'b1;
    tick();
    bus.endTransactionIn = 1'b0;
    compared++;
    if (bus.grantOut !== 4'b0000 || bus.busIdleOut !== 1'b1 || bus.activeMasterOut !== 4'd0) begin
      mismatched++; $display("[TB] FAIL single_release actual=%b/%b/%0d required=0000/1/0",
                             bus.grantOut, bus.busIdleOut, bus.activeMasterOut);
    end
  endtask

  task automatic test_round_robin();
    int zeros;
    int expOwner;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.requestIn = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      zeros = 0;
      while (bus.grantOut == '0 && zeros < 8) begin
        zeros++;
        tick();
      end
`ifdef BUS_ARB_FIXED_PRIORITY_EN
      expOwner = 0;
`else
      expOwner = k % N;
`endif
      compared++;
      if (bus.grantOut !== 4'(1 << expOwner) || bus.activeMasterOut !== 4'(expOwner)) begin
        mismatched++; $display("[TB] FAIL rr_owner%0d actual=%b/%0d required=%b/%0d", k,
                               bus.grantOut, bus.activeMasterOut, 4'(1 << expOwner), expOwner);
      end
      compared++;
      if (zeros !== 1) begin
        mismatched++; $display("[TB] FAIL rr_dead_cycles%0d actual=%0d required=1", k, zeros);
      end
      bus.beginTransactionIn = 1'b1;
      tick();
      bus.beginTransactionIn = 1'b0;
      repeat (3) tick();
      bus.endTransactionIn = 1'b1;
      tick();
      bus.endTransactionIn = 1'b0;
    end
    bus.requestIn = '0;
    tick();
  endtask

  task automatic test_stalled_grant();
    int pulses;
    bus.requestIn = 4'b0100;
    tick();
    bus.requestIn = '0;
    compared++;
    if (bus.grantOut !== 4'b0100 || bus.activeMasterOut !== 4'd2) begin
      mismatched++; $display("[TB] FAIL stall_grant actual=%b/%0d required=0100/2",
                             bus.grantOut, bus.activeMasterOut);
    end
    pulses = 0;
    repeat (15) begin
      tick();
      if (bus.endTransactionOut || bus.busErrorOut) pulses++;
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++; $display("[TB] FAIL stall_early_pulse actual=%0d required=0", pulses);
    end
    tick();
    compared++;
    if ({bus.endTransactionOut, bus.busErrorOut, bus.grantOut} !== 6'b10_0100) begin
      mismatched++; $display("[TB] FAIL stall_abort actual=%b required=100100",
                             {bus.endTransactionOut, bus.busErrorOut, bus.grantOut});
    end
    tick();
    compared++;
    if ({bus.endTransactionOut, bus.busErrorOut, bus.grantOut, bus.busIdleOut} !== 7'b00_0000_1) begin
      mismatched++; $display("[TB] FAIL stall_release actual=%b required=0000001",
                             {bus.endTransactionOut, bus.busErrorOut, bus.grantOut, bus.busIdleOut});
    end
  endtask

  task automatic test_stalled_burst();
    int pulses;
    bus.requestIn = 4'b0001;
    tick();
    bus.requestIn = '0;
    bus.beginTransactionIn = 1'b1;
    tick();
    bus.beginTransactionIn = 1'b0;
    pulses = 0;
    repeat (15) begin
      tick();
      if (bus.endTransactionOut || bus.busErrorOut) pulses++;
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++; $display("[TB] FAIL burst_early_pulse actual=%0d required=0", pulses);
    end
    tick();
    compared++;
    if ({bus.busErrorOut, bus.endTransactionOut, bus.grantOut} !== 6'b10_0001) begin
      mismatched++; $display("[TB] FAIL burst_error actual=%b required=100001",
                             {bus.busErrorOut, bus.endTransactionOut, bus.grantOut});
    end
    tick();
    compared++;
    if ({bus.busErrorOut, bus.endTransactionOut, bus.grantOut} !== 6'b01_0001) begin
      mismatched++; $display("[TB] FAIL burst_end actual=%b required=010001",
                             {bus.busErrorOut, bus.endTransactionOut, bus.grantOut});
    end
    tick();
    compared++;
    if ({bus.busErrorOut, bus.endTransactionOut, bus.grantOut} !== 6'b00_0000) begin
      mismatched++; $display("[TB] FAIL burst_release actual=%b required=000000",
                             {bus.busErrorOut, bus.endTransactionOut, bus.grantOut});
    end
  endtask

  task automatic test_busy_hold();
    int pulses;
    bus.requestIn = 4'b1000;
    tick();
    bus.requestIn = '0;
    bus.beginTransactionIn = 1'b1;
    tick();
    bus.beginTransactionIn = 1'b0;
    bus.busyIn = 1'b1;
    pulses = 0;
    repeat (100) begin
      tick();
      if (bus.endTransactionOut || bus.busErrorOut || bus.grantOut != 4'b1000) pulses++;
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++; $display("[TB] FAIL busy_no_abort actual=%0d bad cycles required=0", pulses);
    end
    bus.busyIn = 1'b0;
    bus.endTransactionIn = 1'b1;
    tick();
    bus.endTransactionIn = 1'b0;
    compared++;
    if (bus.grantOut !== 4'b0000) begin
      mismatched++; $display("[TB] FAIL busy_release actual=%b required=0000", bus.grantOut);
    end
  endtask

  task automatic test_collision();
    bus.requestIn = 4'b0010;
    tick();
    bus.requestIn = '0;
    bus.beginTransactionIn = 1'b1;
    tick();
    bus.beginTransactionIn = 1'b0;
    repeat (15) tick();
    bus.endTransactionIn = 1'b1;
    tick();
    bus.endTransactionIn = 1'b0;
    compared++;
    if ({bus.grantOut, bus.busErrorOut, bus.endTransactionOut} !== 6'b0000_00) begin
      mismatched++; $display("[TB] FAIL collision_release actual=%b required=000000",
                             {bus.grantOut, bus.busErrorOut, bus.endTransactionOut});
    end
    tick();
    compared++;
    if ({bus.busErrorOut, bus.endTransactionOut} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL collision_late_pulse actual=%b required=00",
                             {bus.busErrorOut, bus.endTransactionOut});
    end
  endtask

  task automatic test_reset_mid();
    bus.requestIn = 4'b0100;
    tick();
    bus.beginTransactionIn = 1'b1;
    tick();
    bus.beginTransactionIn = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if ({bus.grantOut, bus.busErrorOut, bus.endTransactionOut} !== 6'b0000_00) begin
      mismatched++; $display("[TB] FAIL reset_mid_drop actual=%b required=000000",
                             {bus.grantOut, bus.busErrorOut, bus.endTransactionOut});
    end
    tick();
    compared++;
    if (bus.grantOut !== 4'b0100) begin
      mismatched++; $display("[TB] FAIL reset_mid_regrant actual=%b required=0100", bus.grantOut);
    end
    bus.requestIn = '0;
    bus.beginTransactionIn = 1'b1;
    tick();
    bus.beginTransactionIn = 1'b0;
    bus.endTransactionIn = 1'b1;
    tick();
    bus.endTransactionIn = 1'b0;
  endtask

  task automatic test_random();
    int         actPct;
    int         bad;
    logic [3:0] expGrant;
    logic [10:0] expVec;
    logic [10:0] actVec;
    reset = 1'b1;
    clearInputs();
    tick();
    reset = 1'b0;
    bad = 0;
    actPct = 30;
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       actPct = 0;
          1:       actPct = 5;
          default: actPct = 30;
        endcase
      end
      bus.requestIn          = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bus.beginTransactionIn = ($urandom_range(0, 99) < actPct);
      bus.dataValidIn        = ($urandom_range(0, 99) < actPct);
      bus.busyIn             = ($urandom_range(0, 99) < actPct / 2);
      bus.endTransactionIn   = ($urandom_range(0, 99) < 10);
      reset                  = ($urandom_range(0, 199) == 0);
      tick();
      expGrant = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
      expVec   = {expGrant, (mOwner < 0) ? 4'd0 : 4'(mOwner), (mOwner < 0), mEnd, mErr};
      actVec   = {bus.grantOut, bus.activeMasterOut, bus.busIdleOut,
                  bus.endTransactionOut, bus.busErrorOut};
      compared++;
      if (actVec !== expVec) begin
        mismatched++;
        bad++;
        if (bad <= 10) $display("[TB] FAIL random_cycle%0d actual=%b required=%b", c, actVec, expVec);
      end
    end
    reset = 1'b0;
    clearInputs();
    tick();
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_single_request();
    test_round_robin();
    test_stalled_grant();
    test_stalled_burst();
    test_busy_hold();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter for the shared system bus.
- Arbitrates requestBus/busGrant between bus masters: camera grabber, DMA engines and CPU bridge.
- Grants exactly one master at a time and holds the grant from grant until that master's endTransaction.
- A watchdog aborts a stalled owner by driving busError plus endTransaction, so a hung master (e.g. grabber stuck in REQUEST/BURST) cannot lock the bus.

Parameters:
- NR_OF_MASTERS, 4, number of requesters; legal range 2..16.
- TIMEOUT_CYCLES, 1024, max consecutive clock cycles without bus activity while a grant is held. Legal range 2..65535.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- requestIn  input  NR_OF_MASTERS  per-master bus request; level, one bit per master.
- grantOut  output  NR_OF_MASTERS  registered one-hot grant; all zero when no owner.
- activeMasterOut  output  4  index of current owner; 0 when idle.
- busIdleOut  output  1  1 when no grant is held.
- beginTransactionIn  input  1  bus beginTransaction (OR of masters).
- dataValidIn  input  1  bus dataValid.
- busyIn  input  1  slave busy.
- endTransactionIn  input  1  bus endTransaction from owner.
- endTransactionOut  output  1  arbiter-forced endTransaction, 1-cycle pulse.
- busErrorOut  output  1  arbiter-forced busError, 1-cycle pulse.

Behaviour:
- Reset: state IDLE, grantOut=0, activeMasterOut=0, busIdleOut=1, endTransactionOut=0, busErrorOut=0, priority pointer=0, watchdog=0.
- All outputs are registered.
- States: IDLE, GRANTED, ACTIVE, ABORT_ERR, ABORT_END.
- IDLE, any requestIn bit set:
  - Select the first set bit scanning from pointer upward, with wrap-around.
  - Grant is visible on the next edge (1-cycle latency); go to GRANTED.
  - Pointer becomes winner+1 modulo NR_OF_MASTERS.
- GRANTED:
  - Grant is held even if the request drops; masters deassert request after grant.
  - beginTransactionIn → ACTIVE.
  - Watchdog expiry → ABORT_END (no error; the master never started).
- ACTIVE:
  - endTransactionIn → IDLE, grantOut cleared on the same edge.
  - Watchdog expiry → ABORT_ERR.
- ABORT_ERR: busErrorOut=1 for one cycle → ABORT_END.
- ABORT_END: endTransactionOut=1 for one cycle, grant still held → IDLE with grant cleared.
- Dead cycle: at least one cycle of grantOut=0 between any two owners. A request present in the cycle grant drops is served on the cycle after.
- Watchdog:
  - Cleared on entry to GRANTED and on any cycle with beginTransactionIn, dataValidIn or busyIn high.
  - Otherwise increments; expiry when count reaches TIMEOUT_CYCLES-1.
  - Saturates and is inactive in IDLE.
- Simultaneous endTransactionIn and watchdog expiry: endTransactionIn wins, normal release, no error.
- endTransactionIn or beginTransactionIn in IDLE: ignored.
- Reset mid-transaction: grant dropped next edge, no forced end/error pulse.
- requestIn bits ≥ NR_OF_MASTERS do not exist. activeMasterOut is zero-extended.

Optional Feature:
- Macro BUS_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins. The pointer is held at 0 and never updated; all else unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single request: requestIn=0010 at cycle 0 → grantOut=0010, activeMasterOut=1 at cycle 1. beginTransaction at cycle 3, endTransactionIn at cycle 10 → grantOut=0 at cycle 11, busIdleOut=1.
- Round-robin: requestIn=1111 held, each master ends after 5 cycles → grant order 0,1,2,3,0. Exactly one zero-grant cycle between owners. With BUS_ARB_FIXED_PRIORITY_EN → always master 0.
- Stalled grant, TIMEOUT_CYCLES=16: grant to master 2, no beginTransaction → endTransactionOut pulse 16 cycles after grant, busErrorOut stays 0, grant cleared next cycle.
- Stalled burst: begin then silence with busyIn=0 for 16 cycles → busErrorOut pulse, then endTransactionOut pulse next cycle, then grant=0. busyIn held high 100 cycles → no abort.
- Collision: endTransactionIn coincides with watchdog expiry → normal release, busErrorOut=0, endTransactionOut=0.
- Reset during ACTIVE with requestIn=0100 still high → grant=0 after reset edge, pointer=0; regrant to master 2 one cycle after reset deasserts.
